motor_pwm: RTL and testbench

MOTOR_PWM -- requirements
Module: motor_pwm

---
 rtl/motor_pkg.sv | 20 ++
 rtl/pwm_deadtime.sv | 85 ++++++++
 rtl/motor_pwm.sv | 103 ++++++++++
 tb/tb_motor_pwm.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared types and constants for the motor PWM bridge driver.
`default_nettype none

package motor_pkg;

    localparam int PWM_PERIOD_MAX       = 4094;
    localparam int PWM_DEADTIME_DEFAULT = 4;

    typedef logic [11:0] duty_t;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        DEAD = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } pwm_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: half-bridge gate FSM inserting DEADTIME idle cycles between
// high-side and low-side conduction; both gate outputs are registered.
`default_nettype none

module pwm_deadtime
    import motor_pkg::*;
#(
    parameter int DEADTIME = PWM_DEADTIME_DEFAULT
) (
    input  logic c20k,
    input  logic reset_n,
    input  logic raw,
    input  logic Enable,
    output logic PwmHigh,
    output logic PwmLow,
    output logic Active
);

    // Dead counter runs DEADTIME-1 down to 0, giving exactly DEADTIME cycles.
    localparam logic [3:0] DEAD_LOAD = 4'(DEADTIME - 1);

    pwm_state_t state_q;
    logic [3:0] dead_q;
    logic       high_q;
    logic       low_q;

    always_ff @(posedge c20k or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= OFF;
            dead_q  <= '0;
            high_q  <= 1'b0;
            low_q   <= 1'b0;
        end else if (!Enable) begin
            state_q <= OFF;
            dead_q  <= '0;
            high_q  <= 1'b0;
            low_q   <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    state_q <= DEAD;
                    dead_q  <= DEAD_LOAD;
                    high_q  <= 1'b0;
                    low_q   <= 1'b0;
                end
                DEAD: begin
                    if (dead_q == 4'd0) begin
                        state_q <= raw ? HIGH : LOW;
                        high_q  <= raw;
                        low_q   <= ~raw;
                    end else begin
                        dead_q  <= dead_q - 4'd1;
                    end
                end
                HIGH: begin
                    if (!raw) begin
                        state_q <= DEAD;
                        dead_q  <= DEAD_LOAD;
                        high_q  <= 1'b0;
                    end
                end
                LOW: begin
                    if (raw) begin
                        state_q <= DEAD;
                        dead_q  <= DEAD_LOAD;
                        low_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= OFF;
                    dead_q  <= '0;
                    high_q  <= 1'b0;
                    low_q   <= 1'b0;
                end
            endcase
        end
    end

    assign PwmHigh = high_q;
    assign PwmLow  = low_q;
    assign Active  = (state_q != OFF);

endmodule

`default_nettype wire

// File: rtl/motor_pwm.sv
// motor_pwm: edge-aligned PWM with shadowed duty and dead-time bridge drive.
// Optional ADC sample trigger centred in the on-time: define PWM_SAMPLE_TRIG_EN.
`default_nettype none

module motor_pwm
    import motor_pkg::*;
#(
    parameter int DEADTIME   = PWM_DEADTIME_DEFAULT,
    parameter int PERIOD_MAX = PWM_PERIOD_MAX
) (
    input  logic        c20k,
    input  logic        reset_n,
    input  logic [11:0] MotorSignal,
    input  logic        Enable,
    output logic        PwmHigh,
    output logic        PwmLow,
    output logic        PeriodStart,
    output logic        SampleStrobe
);

    localparam duty_t CNT_MAX = duty_t'(PERIOD_MAX);

    duty_t count_q;
    duty_t count_d;
    duty_t shadow_q;
    duty_t shadow_d;
    logic  period_start_q;
    logic  period_start_d;
    logic  raw;
    logic  active;

    assign raw = (count_q < shadow_q);

    // The first enabled edge restarts the period and takes the duty directly.
    always_comb begin
        count_d  = count_q;
        shadow_d = shadow_q;
        if (!Enable) begin
            count_d  = '0;
        end else if (!active) begin
            count_d  = '0;
            shadow_d = MotorSignal;
        end else if (count_q == CNT_MAX) begin
            count_d  = '0;
            shadow_d = MotorSignal;
        end else begin
            count_d  = count_q + 12'd1;
        end
    end

    // The FSM is non-OFF after this edge exactly when Enable is high now.
    assign period_start_d = Enable && (count_d == '0);

    always_ff @(posedge c20k or negedge reset_n) begin
        if (!reset_n) begin
            count_q        <= '0;
            shadow_q       <= '0;
            period_start_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            shadow_q       <= shadow_d;
            period_start_q <= period_start_d;
        end
    end

    assign PeriodStart = period_start_q;

    pwm_deadtime #(
        .DEADTIME (DEADTIME)
    ) u_deadtime (
        .c20k    (c20k),
        .reset_n (reset_n),
        .raw     (raw),
        .Enable  (Enable),
        .PwmHigh (PwmHigh),
        .PwmLow  (PwmLow),
        .Active  (active)
    );

`ifdef PWM_SAMPLE_TRIG_EN
    localparam duty_t SAMPLE_MIN = duty_t'(2 * DEADTIME);

    logic sample_q;
    logic sample_d;

    assign sample_d = Enable && (shadow_d >= SAMPLE_MIN) && (count_d == (shadow_d >> 1));

    always_ff @(posedge c20k or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= 1'b0;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign SampleStrobe = sample_q;
`else
    assign SampleStrobe = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_motor_pwm.sv
// tb_motor_pwm: self-checking bench for motor_pwm against a cycle-level
// behavioural model of counter, duty shadow and dead-time gate drive.
`default_nettype none

module tb_motor_pwm;

    localparam int DT   = 4;
    localparam int PMAX = 4094;
    localparam int PER  = PMAX + 1;
`ifdef PWM_SAMPLE_TRIG_EN
    localparam bit TRIG = 1'b1;
`else
    localparam bit TRIG = 1'b0;
`endif

    localparam int PH_OFF  = 0;
    localparam int PH_DEAD = 1;
    localparam int PH_HIGH = 2;
    localparam int PH_LOW  = 3;

    logic        c20k        = 1'b0;
    logic        reset_n     = 1'b1;
    logic        Enable      = 1'b0;
    logic [11:0] MotorSignal = 12'd0;
    logic        PwmHigh;
    logic        PwmLow;
    logic        PeriodStart;
    logic        SampleStrobe;

    int errors = 0;
    int checks = 0;

    bit m_run;
    int m_ph, m_dead, m_cnt, m_sh;
    int acc_hi, acc_lo, acc_gap, acc_ss, ss_at;

    motor_pwm #(
        .DEADTIME   (DT),
        .PERIOD_MAX (PMAX)
    ) dut (
        .c20k         (c20k),
        .reset_n      (reset_n),
        .MotorSignal  (MotorSignal),
        .Enable       (Enable),
        .PwmHigh      (PwmHigh),
        .PwmLow       (PwmLow),
        .PeriodStart  (PeriodStart),
        .SampleStrobe (SampleStrobe)
    );

    always #5 c20k = ~c20k;

    always @(negedge c20k) begin
        checks++;
        assert (!(PwmHigh && PwmLow)) else begin
            errors++;
            $display("FAIL overlap t=%0t PwmHigh=%b PwmLow=%b required not both 1", $time, PwmHigh, PwmLow);
        end
    end

    task automatic model_reset();
        m_run = 1'b0; m_ph = PH_OFF; m_dead = 0; m_cnt = 0; m_sh = 0;
    endtask

    // One rising edge of the spec's behaviour, using pre-edge count/duty.
    task automatic model_edge(input bit en, input int ms);
        bit raw;
        raw = (m_cnt < m_sh);
        if (!en) begin
            m_run = 1'b0; m_ph = PH_OFF; m_cnt = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_ph = PH_DEAD; m_dead = DT; m_cnt = 0; m_sh = ms;
        end else begin
            if (m_ph == PH_DEAD) begin
                if (m_dead > 1) m_dead--;
                else m_ph = raw ? PH_HIGH : PH_LOW;
            end else if (m_ph == PH_HIGH && !raw) begin
                m_ph = PH_DEAD; m_dead = DT;
            end else if (m_ph == PH_LOW && raw) begin
                m_ph = PH_DEAD; m_dead = DT;
            end
            if (m_cnt == PMAX) begin
                m_cnt = 0; m_sh = ms;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic tick();
        bit e_hi, e_lo, e_ps, e_ss;
        @(posedge c20k);
        #1;
        if (!reset_n) model_reset();
        else model_edge(Enable, int'(MotorSignal));
        e_hi = (m_ph == PH_HIGH);
        e_lo = (m_ph == PH_LOW);
        e_ps = m_run && (m_cnt == 0);
        e_ss = TRIG && m_run && (m_sh >= 2 * DT) && (m_cnt == m_sh / 2);
        checks += 4;
        if (PwmHigh !== e_hi) begin
            errors++; $display("FAIL PwmHigh cnt=%0d got=%b exp=%b", m_cnt, PwmHigh, e_hi);
        end
        if (PwmLow !== e_lo) begin
            errors++; $display("FAIL PwmLow cnt=%0d got=%b exp=%b", m_cnt, PwmLow, e_lo);
        end
        if (PeriodStart !== e_ps) begin
            errors++; $display("FAIL PeriodStart cnt=%0d got=%b exp=%b", m_cnt, PeriodStart, e_ps);
        end
        if (SampleStrobe !== e_ss) begin
            errors++; $display("FAIL SampleStrobe cnt=%0d got=%b exp=%b", m_cnt, SampleStrobe, e_ss);
        end
        acc_hi  += int'(PwmHigh);
        acc_lo  += int'(PwmLow);
        acc_gap += int'(!PwmHigh && !PwmLow);
        if (SampleStrobe) begin
            acc_ss++; ss_at = m_cnt;
        end
    endtask

    task automatic clear_acc();
        acc_hi = 0; acc_lo = 0; acc_gap = 0; acc_ss = 0; ss_at = -1;
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < PER + 2; i++) begin
            if (m_run && m_cnt == target) return;
            tick();
        end
        errors++;
        $display("FAIL wait_cnt timeout got=%0d required=%0d", m_cnt, target);
    endtask

    // One full period starting from count PMAX; optional mid-period duty change.
    task automatic measure(input int chg_at, input int chg_val);
        clear_acc();
        for (int i = 0; i < PER; i++) begin
            tick();
            if (m_cnt == chg_at) MotorSignal = 12'(chg_val);
        end
    endtask

    task automatic check_period(input string name, input int hi, input int lo, input int gap);
        checks += 3;
        if (acc_hi !== hi) begin
            errors++; $display("FAIL %s hi_cycles got=%0d exp=%0d", name, acc_hi, hi);
        end
        if (acc_lo !== lo) begin
            errors++; $display("FAIL %s lo_cycles got=%0d exp=%0d", name, acc_lo, lo);
        end
        if (acc_gap !== gap) begin
            errors++; $display("FAIL %s gap_cycles got=%0d exp=%0d", name, acc_gap, gap);
        end
    endtask

    task automatic check_strobe(input string name, input int duty);
        int e_n, e_at;
        e_n  = (TRIG && duty >= 2 * DT) ? 1 : 0;
        e_at = (e_n == 1) ? duty / 2 : -1;
        checks += 2;
        if (acc_ss !== e_n) begin
            errors++; $display("FAIL %s strobe_count got=%0d exp=%0d", name, acc_ss, e_n);
        end
        if (ss_at !== e_at) begin
            errors++; $display("FAIL %s strobe_at got=%0d exp=%0d", name, ss_at, e_at);
        end
    endtask

    task automatic test_reset();
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({PwmHigh, PwmLow, PeriodStart, SampleStrobe} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000", {PwmHigh, PwmLow, PeriodStart, SampleStrobe});
        end
        for (int i = 0; i < 3; i++) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_half_duty();
        MotorSignal = 12'd2048;
        Enable      = 1'b1;
        tick();
        checks++;
        if ({PeriodStart, PwmHigh, PwmLow} !== 3'b100) begin
            errors++; $display("FAIL first_enable got=%b exp=100", {PeriodStart, PwmHigh, PwmLow});
        end
        wait_cnt(PMAX);
        measure(-1, 0);
        check_period("half_duty", 2048 - DT, PER - 2048 - DT, 2 * DT);
        check_strobe("half_duty", 2048);
    endtask

    task automatic test_shadow();
        MotorSignal = 12'd1000;
        measure(500, 3000);
        check_period("shadow_1000", 1000 - DT, PER - 1000 - DT, 2 * DT);
        check_strobe("shadow_1000", 1000);
        measure(-1, 0);
        check_period("shadow_3000", 3000 - DT, PER - 3000 - DT, 2 * DT);
        check_strobe("shadow_3000", 3000);
    endtask

    task automatic test_boundaries();
        MotorSignal = 12'd0;
        measure(-1, 0);
        check_period("duty_0", 0, PER, 0);
        check_strobe("duty_0", 0);
        MotorSignal = 12'd4095;
        measure(-1, 0);
        check_period("duty_4095", PER - 1 - DT, 1, DT);
        check_strobe("duty_4095", 4095);
    endtask

    task automatic test_enable();
        Enable = 1'b0;
        tick();
        MotorSignal = 12'd6;
        Enable      = 1'b1;
        wait_cnt(5);
        checks++;
        if (PwmHigh !== 1'b1) begin
            errors++; $display("FAIL pre_drop_high got=%b exp=1", PwmHigh);
        end
        Enable = 1'b0;
        tick();
        checks++;
        if ({PwmHigh, PwmLow} !== 2'b00) begin
            errors++; $display("FAIL enable_drop got=%b exp=00", {PwmHigh, PwmLow});
        end
        for (int i = 0; i < 3; i++) tick();
        Enable = 1'b1;
        clear_acc();
        tick();
        checks++;
        if (PeriodStart !== 1'b1) begin
            errors++; $display("FAIL reenable_period_start got=%b exp=1", PeriodStart);
        end
        for (int i = 0; i < DT - 1; i++) tick();
        checks++;
        if (acc_gap !== DT) begin
            errors++; $display("FAIL reenable_dead got=%0d exp=%0d", acc_gap, DT);
        end
        tick();
        checks++;
        if (PwmHigh !== 1'b1) begin
            errors++; $display("FAIL reenable_high got=%b exp=1", PwmHigh);
        end
        wait_cnt(PMAX);
        check_strobe("duty_6", 6);
    endtask

    task automatic test_reset_mid();
        MotorSignal = 12'd2000;
        wait_cnt(1234);
        checks++;
        if (PwmHigh !== 1'b1) begin
            errors++; $display("FAIL mid_high got=%b exp=1", PwmHigh);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({PwmHigh, PwmLow, PeriodStart, SampleStrobe} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got=%b exp=0000", {PwmHigh, PwmLow, PeriodStart, SampleStrobe});
        end
        model_reset();
        #1 reset_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 10 * PER; i++) begin
            if ($urandom_range(199) == 0) begin
                case ($urandom_range(3))
                    0:       MotorSignal = 12'($urandom_range(15));
                    1:       MotorSignal = 12'($urandom_range(4095, 4080));
                    default: MotorSignal = 12'($urandom_range(4095));
                endcase
            end
            if (Enable && $urandom_range(2999) == 0) Enable = 1'b0;
            else if (!Enable && $urandom_range(7) == 0) Enable = 1'b1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_half_duty();
        test_shadow();
        test_boundaries();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
